lmsm_sequencer: RTL and testbench

Multi-cycle sequencer for the pipeline's load-multiple and store-multiple instructions (LM, SM, and optionally LA, SA). It sits beside the ID stage. It accepts one multi-register operation at a time and emits one register/address pair per cycle toward the register-file and data-memory ports. While it runs, it holds the fetch/decode stages and produces a single-cycle completion pulse.

---
 rtl/lmsm_sequencer.sv | 128 ++++++++++++
 tb/tb_lmsm_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: walks a register mask for LM/SM (and LA/SA) one register per
// step, emitting register index, memory address, store flag and last flag.
// Holds IF/ID while running and pulses done for one cycle on completion.
// Optional feature macro: LMSM_ALL_MODE_EN (LA/SA select all NREG registers).
module lmsm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [NREG-1:0]   mask,
  input  logic [ADDR_W-1:0] base,
  input  logic              advance,
  input  logic              flush,
  output logic              busy,
  output logic              hold,
  output logic              step_valid,
  output logic [2:0]        step_reg,
  output logic [ADDR_W-1:0] step_addr,
  output logic              step_store,
  output logic              step_last,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NREG-1:0]     mask_q, mask_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                store_q, store_d;
  logic [NREG-1:0]     mask_eff;
  logic [NREG-1:0]     mask_rest;

`ifdef LMSM_ALL_MODE_EN
  // LA/SA override the supplied mask with every register
  always_comb begin
    mask_eff = op[1] ? {NREG{1'b1}} : mask;
  end
`else
  // op[1] has no meaning without the all-register mode
  logic unused_op_hi;
  assign unused_op_hi = op[1];

  // the supplied mask is always used as-is
  always_comb begin
    mask_eff = mask;
  end
`endif

  // remaining mask once the lowest set bit has been consumed
  always_comb begin
    mask_rest = mask_q & (mask_q - NREG'(1));
  end

  // state, latched operation and step counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
    end
  end

  // next-state logic: accept in IDLE, consume one bit per advance in RUN
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          mask_d  = mask_eff;
          base_d  = base;
          cnt_d   = '0;
          store_d = op[0];
          state_d = (mask_eff != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (advance) begin
          mask_d = mask_rest;
          cnt_d  = cnt_q + ADDR_W'(1);
          if (mask_rest == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs: step fields come from registered state only; hold also sees start
  always_comb begin
    busy       = (state_q != S_IDLE);
    hold       = (state_q == S_RUN) ||
                 ((state_q == S_IDLE) && start && (mask_eff != '0) && !flush);
    step_valid = (state_q == S_RUN);
    step_reg   = 3'd0;
    if (state_q == S_RUN) begin
      for (int i = NREG - 1; i >= 0; i--) begin
        if (mask_q[i]) step_reg = 3'(i);
      end
    end
    step_addr  = (state_q == S_RUN) ? (base_q + cnt_q) : '0;
    step_store = (state_q == S_RUN) && store_q;
    step_last  = (state_q == S_RUN) && (mask_rest == '0);
    done       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  mask;
  logic [15:0] base;
  logic        advance;
  logic        flush;
  logic        busy, hold, step_valid, step_store, step_last, done;
  logic [2:0]  step_reg;
  logic [15:0] step_addr;

  lmsm_sequencer #(.ADDR_W(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .mask(mask), .base(base),
    .advance(advance), .flush(flush), .busy(busy), .hold(hold),
    .step_valid(step_valid), .step_reg(step_reg), .step_addr(step_addr),
    .step_store(step_store), .step_last(step_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
    logic        s;
    logic        l;
  } step_t;

  step_t sbq[$];
  int    total = 0;
  int    bad   = 0;
  logic  chk_en = 1'b0;
  logic  exp_busy, exp_hold, exp_valid, exp_done;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: compares control outputs every cycle, pops a step when it is accepted
  always @(negedge clk) begin
    step_t e;
    if (rst_n && chk_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("hold", 32'(hold), 32'(exp_hold));
      check("done", 32'(done), 32'(exp_done));
      check("step_valid", 32'(step_valid), 32'(exp_valid));
      if (step_valid) begin
        if (sbq.size() == 0) begin
          check("sb_empty", 32'(step_reg), 32'hFFFF_FFFF);
        end else begin
          e = sbq[0];
          check("step_reg", 32'(step_reg), 32'(e.r));
          check("step_addr", 32'(step_addr), 32'(e.a));
          check("step_store", 32'(step_store), 32'(e.s));
          check("step_last", 32'(step_last), 32'(e.l));
          if (advance && !flush) e = sbq.pop_front();
        end
      end
    end
  end

  task automatic set_exp(input logic b, input logic h, input logic v, input logic d);
    exp_busy = b; exp_hold = h; exp_valid = v; exp_done = d;
  endtask

  // issue one operation; the expected step list comes from the mask rules
  task automatic run_op(input logic [1:0] o, input logic [7:0] m, input logic [15:0] b,
                        input int adv_pct, input int stall_first, input int flush_at,
                        input bit noise);
    logic [7:0]  eff;
    int          k, n, acc, cyc;
    bit          flushed;
    step_t       s;
    eff = m;
`ifdef LMSM_ALL_MODE_EN
    if (o[1]) eff = 8'hFF;
`endif
    k = $countones(eff);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (eff[i]) begin
        s.r = 3'(i); s.a = b + 16'(n); s.s = o[0]; s.l = (n == k - 1);
        sbq.push_back(s);
        n++;
      end
    end
    start = 1'b1; op = o; mask = m; base = b; flush = 1'b0; advance = 1'($urandom);
    set_exp(1'b0, k != 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0; cyc = 0; flushed = 1'b0;
    while (acc < k && cyc < 200 && !flushed) begin
      set_exp(1'b1, 1'b1, 1'b1, 1'b0);
      advance = (cyc < stall_first) ? 1'b0 : 1'($urandom_range(0, 99) < adv_pct);
      flush = (cyc == flush_at);
      if (noise) begin
        start = 1'($urandom); op = 2'($urandom); mask = 8'($urandom); base = 16'($urandom);
      end
      @(posedge clk); #1;
      if (flush) flushed = 1'b1;
      else if (advance) acc++;
      cyc++;
    end
    flush = 1'b0;
    if (flushed) begin
      sbq.delete();
      start = 1'b0;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      $display("op=%0d mask=%02h base=%04h flushed after %0d cycles", o, m, b, cyc);
      return;
    end
    set_exp(1'b1, 1'b0, 1'b0, 1'b1);
    advance = 1'($urandom);
    start = noise ? 1'b1 : 1'b0;
    mask = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    $display("op=%0d mask=%02h base=%04h steps=%0d cycles=%0d", o, m, b, k, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; mask = 8'h00; base = 16'h0000;
    advance = 1'b0; flush = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(step_valid), 32'd0);
    check("rst_addr", 32'(step_addr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op(2'b00, 8'b1010_0100, 16'h0010, 100, 0, -1, 1'b0);
    run_op(2'b01, 8'h03, 16'hFFFF, 100, 2, -1, 1'b0);
    run_op(2'b00, 8'h00, 16'h1234, 100, 0, -1, 1'b0);
    run_op(2'b00, 8'hFF, 16'h0100, 100, 0, 1, 1'b0);
    run_op(2'b01, 8'h81, 16'h0200, 100, 0, -1, 1'b0);
    run_op(2'b10, 8'h00, 16'h0020, 100, 0, -1, 1'b0);
    run_op(2'b11, 8'h18, 16'h0030, 70, 0, -1, 1'b1);

    // start together with flush in IDLE is ignored
    start = 1'b1; flush = 1'b1; op = 2'b00; mask = 8'hFF;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    $display("start+flush in idle ignored");

    // asynchronous reset in the middle of RUN
    begin
      step_t s;
      for (int i = 0; i < 8; i++) begin
        s.r = 3'(i); s.a = 16'h0040 + 16'(i); s.s = 1'b1; s.l = (i == 7);
        sbq.push_back(s);
      end
      start = 1'b1; op = 2'b01; mask = 8'hFF; base = 16'h0040; advance = 1'b1;
      set_exp(1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      set_exp(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_hold", 32'(hold), 32'd0);
      check("mid_rst_valid", 32'(step_valid), 32'd0);
      check("mid_rst_reg", 32'(step_reg), 32'd0);
      check("mid_rst_addr", 32'(step_addr), 32'd0);
      check("mid_rst_store", 32'(step_store), 32'd0);
      check("mid_rst_last", 32'(step_last), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      sbq.delete();
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      $display("reset mid-operation");
      run_op(2'b00, 8'h01, 16'h0050, 100, 0, -1, 1'b0);
    end

    // randomized operations
    for (int t = 0; t < 25; t++) begin
      run_op(2'($urandom), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
             16'($urandom), $urandom_range(40, 100), $urandom_range(0, 2),
             ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1, 1'b1);
    end

    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
